// File: rtl/vga_rx_timing.sv
`timescale 1ns/1ps
// vga_rx_timing: measures incoming VGA sync timing, recovers pixel coordinates and qualifies locked pixels
module vga_rx_timing #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 34,
    parameter int V_ACTIVE = 480,
    parameter int CNT_MAX  = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] rgb_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pix_valid,
    output logic [2:0] rgb_out,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic       timing_err
);
    localparam logic [9:0] HT = 10'(H_TOTAL);
    localparam logic [9:0] VT = 10'(V_TOTAL);
    localparam logic [9:0] HS = 10'(H_START);
    localparam logic [9:0] HE = 10'(H_START + H_ACTIVE - 1);
    localparam logic [9:0] VS = 10'(V_START);
    localparam logic [9:0] VE = 10'(V_START + V_ACTIVE - 1);
    localparam logic [9:0] CM = 10'(CNT_MAX);

    typedef enum logic [1:0] {UNLOCK, CHECK, LOCK} state_t;

    state_t     state, state_nx;
    logic       s1_hs, s1_vs, s2_hs, s2_vs;
    logic [2:0] s1_rgb, s2_rgb;
    logic [9:0] hcnt, vcnt, h_len, v_len;
    logic       h_seen, v_seen, vs_pend;
    logic       hs_fall, vs_fall, v_restart, window, viol;

    // edge detection, measurements, violation detection and lock next-state
    always_comb begin
        hs_fall   = s2_hs & ~s1_hs;
        vs_fall   = s2_vs & ~s1_vs;
        v_restart = hs_fall & (vs_pend | vs_fall);
        h_len     = hcnt + 10'd1;
        v_len     = vcnt + 10'd1;
        window    = hcnt >= HS && hcnt <= HE && vcnt >= VS && vcnt <= VE;
        viol      = (hs_fall && h_seen && h_len != HT)
                  | (v_restart && v_seen && v_len != VT)
                  | (!hs_fall && hcnt == CM - 10'd1)
                  | (hs_fall && !v_restart && vcnt == CM - 10'd1 && state != UNLOCK);
        state_nx  = (viol && state != UNLOCK) ? UNLOCK :
                    !v_restart                ? state  :
                    state == UNLOCK           ? CHECK  : LOCK;
        locked    = state == LOCK;
    end

    // two-stage input synchroniser; s2 is one tick older than s1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {s1_hs, s1_vs, s1_rgb} <= '0;
            {s2_hs, s2_vs, s2_rgb} <= '0;
        end else if (p_tick) begin
            {s1_hs, s1_vs, s1_rgb} <= {hsync_in, vsync_in, rgb_in};
            {s2_hs, s2_vs, s2_rgb} <= {s1_hs, s1_vs, s1_rgb};
        end
    end

    // line/frame counters and their length measurements; vcnt starts saturated until a frame is seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt    <= '0;
            vcnt    <= CM;
            h_total <= '0;
            v_total <= '0;
            h_seen  <= 1'b0;
            v_seen  <= 1'b0;
            vs_pend <= 1'b0;
        end else if (p_tick) begin
            hcnt    <= hs_fall ? '0 : hcnt == CM ? hcnt : h_len;
            vs_pend <= (vs_pend | vs_fall) & ~hs_fall;
            if (hs_fall) begin
                h_seen <= 1'b1;
                if (h_seen) h_total <= h_len;
            end
            if (v_restart) begin
                vcnt   <= '0;
                v_seen <= 1'b1;
                if (v_seen) v_total <= v_len;
            end else if (hs_fall && vcnt != CM) begin
                vcnt <= v_len;
            end
        end
    end

    // pixel output register; coordinates hold outside the active window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_x   <= '0;
            pixel_y   <= '0;
            rgb_out   <= '0;
            pix_valid <= 1'b0;
        end else if (p_tick) begin
            rgb_out   <= s2_rgb;
            pix_valid <= window & locked;
            if (window) begin
                pixel_x <= hcnt - HS;
                pixel_y <= vcnt - VS;
            end
        end
    end

    // lock state register and single-clk event pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= UNLOCK;
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            frame_start <= p_tick & v_restart;
            timing_err  <= p_tick & viol & (state != UNLOCK);
            if (p_tick) state <= state_nx;
        end
    end
endmodule

// File: tb/tb_vga_rx_timing.sv
`timescale 1ns/1ps
// tb_vga_rx_timing: frame-table and corner-case checks on a scaled-down raster
module tb_vga_rx_timing;
    localparam int HT = 32, VT = 16, HS = 8, HA = 20, VS = 3, VA = 10, SYNC = 5;

    logic       clk = 1'b0, reset = 1'b0, p_tick = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [2:0] rgb_in = '0;
    logic [9:0] pixel_x, pixel_y, h_total, v_total;
    logic [2:0] rgb_out;
    logic       pix_valid, frame_start, locked, timing_err;

    vga_rx_timing #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .H_ACTIVE(HA),
                    .V_START(VS), .V_ACTIVE(VA), .CNT_MAX(1023)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_valid(pix_valid),
        .rgb_out(rgb_out), .frame_start(frame_start), .locked(locked), .h_total(h_total),
        .v_total(v_total), .timing_err(timing_err));

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    int errs = 0, fs = 0, pix = 0, h_at_err = 0, ex = 0, ey = 0;
    logic pt_s;

    typedef struct {
        int sl; int len; int lk; int ne; int hae; int ht; int vt; int np; int nf;
    } vec_t;
    vec_t tv[11];

    function automatic logic [2:0] rgb_of(input int x, input int y);
        return (x == 0 && y == 0) ? 3'b101 : (x == HA - 1 && y == VA - 1) ? 3'b011 : 3'(x + 2 * y);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_zero(input string t);
        check({t, " pixel_x"}, int'(pixel_x), 0);
        check({t, " pixel_y"}, int'(pixel_y), 0);
        check({t, " h_total"}, int'(h_total), 0);
        check({t, " v_total"}, int'(v_total), 0);
        check({t, " valid/fs/locked/err/rgb"},
              int'({pix_valid, frame_start, locked, timing_err, rgb_out}), 0);
    endtask

    // one pixel tick every 4 clk, inputs driven 1ns after an edge
    task automatic tick(input logic hs, input logic vs, input logic [2:0] c);
        hsync_in = hs; vsync_in = vs; rgb_in = c; p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic line(input int l, input int len, input int gate);
        for (int g = 0; g < len; g++) begin
            tick(g >= SYNC, l >= 2,
                 (g >= HS && g < HS + HA && l >= VS && l < VS + VA) ? rgb_of(g - HS, l - VS) : 3'b000);
            if (g == gate) begin
                repeat (50) @(posedge clk);
                #1;
                check("gate pixel_x", int'(pixel_x), gate - 2 - HS);
                check("gate pixel_y", int'(pixel_y), l - VS);
                check("gate rgb_out", int'(rgb_out), int'(rgb_of(gate - 2 - HS, l - VS)));
                check("gate pix_valid", int'(pix_valid), 1);
            end
        end
    endtask

    task automatic frame(input int sl, input int len, input int gate_l, input int gate);
        for (int l = 0; l < VT; l++) line(l, (l == sl) ? len : HT, (l == gate_l) ? gate : -1);
    endtask

    // event counters and raster-order pixel scoreboard
    always @(posedge clk) begin
        pt_s = p_tick;
        #1;
        if (timing_err) begin
            errs++;
            h_at_err = int'(h_total);
        end
        if (frame_start) begin
            fs++;
            ex = 0;
            ey = 0;
        end
        if (pt_s && pix_valid) begin
            pix++;
            checks++;
            if (int'(pixel_x) == ex && int'(pixel_y) == ey && rgb_out == rgb_of(ex, ey)) passed++;
            else $display("FAIL pixel: got x=%0d y=%0d rgb=%b expected x=%0d y=%0d rgb=%b",
                          pixel_x, pixel_y, rgb_out, ex, ey, rgb_of(ex, ey));
            ex++;
            if (ex == HA) begin
                ex = 0;
                ey = (ey == VA - 1) ? 0 : ey + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{-1, 32, 0, 0, 0,  32, 0,  0,   0};
        tv[1]  = '{-1, 32, 0, 0, 0,  32, 0,  0,   1};
        tv[2]  = '{-1, 32, 1, 0, 0,  32, 16, 200, 1};
        tv[3]  = '{-1, 32, 1, 0, 0,  32, 16, 200, 1};
        tv[4]  = '{5,  31, 0, 1, 31, 32, 16, 60,  1};
        tv[5]  = '{-1, 32, 0, 0, 0,  32, 16, 0,   1};
        tv[6]  = '{-1, 32, 1, 0, 0,  32, 16, 200, 1};
        tv[7]  = '{10, 33, 0, 1, 33, 32, 16, 160, 1};
        tv[8]  = '{4,  31, 0, 1, 31, 32, 16, 0,   1};
        tv[9]  = '{-1, 32, 0, 0, 0,  32, 16, 0,   1};
        tv[10] = '{-1, 32, 1, 0, 0,  32, 16, 200, 1};

        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        #2 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            errs = 0; fs = 0; pix = 0; h_at_err = 0;
            frame(tv[i].sl, tv[i].len, -1, -1);
            check($sformatf("f%0d locked", i + 1), int'(locked), tv[i].lk);
            check($sformatf("f%0d errs", i + 1), errs, tv[i].ne);
            check($sformatf("f%0d h_at_err", i + 1), h_at_err, tv[i].hae);
            check($sformatf("f%0d h_total", i + 1), int'(h_total), tv[i].ht);
            check($sformatf("f%0d v_total", i + 1), int'(v_total), tv[i].vt);
            check($sformatf("f%0d pix", i + 1), pix, tv[i].np);
            check($sformatf("f%0d frame_starts", i + 1), fs, tv[i].nf);
        end

        errs = 0; pix = 0;
        frame(-1, HT, 5, 12);
        check("gate locked", int'(locked), 1);
        check("gate errs", errs, 0);
        check("gate h_total", int'(h_total), HT);
        check("gate pix", pix, HA * VA);

        errs = 0;
        for (int l = 0; l < 3; l++) line(l, HT, -1);
        repeat (1100) tick(1'b1, 1'b1, 3'b000);
        check("hlost errs", errs, 1);
        check("hlost locked", int'(locked), 0);
        check("hlost pix_valid", int'(pix_valid), 0);
        check("hlost h_total", int'(h_total), HT);

        errs = 0; fs = 0;
        frame(-1, HT, -1, -1);
        check("relock1 locked", int'(locked), 0);
        check("relock1 errs", errs, 0);
        check("relock1 v_total", int'(v_total), 3);
        check("relock1 frame_starts", fs, 1);
        frame(-1, HT, -1, -1);
        check("relock2 locked", int'(locked), 1);
        check("relock2 v_total", int'(v_total), VT);

        errs = 0;
        for (int l = 0; l < 7; l++) line(l, HT, -1);
        line(7, 15, -1);
        check("prereset locked", int'(locked), 1);
        #3 reset = 1'b0;
        #1 check_zero("midreset");
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        for (int l = 8; l < VT; l++) line(l, HT, -1);
        check("postreset locked", int'(locked), 0);
        check("postreset h_total", int'(h_total), HT);
        check("postreset v_total", int'(v_total), 0);
        fs = 0;
        frame(-1, HT, -1, -1);
        check("rst f1 locked", int'(locked), 0);
        check("rst f1 frame_starts", fs, 1);
        check("rst f1 v_total", int'(v_total), 0);
        pix = 0;
        frame(-1, HT, -1, -1);
        check("rst f2 locked", int'(locked), 1);
        check("rst f2 v_total", int'(v_total), VT);
        check("rst errs", errs, 0);
        check("rst f2 pix", pix, HA * VA);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/vga_rx_timing.md
Name: vga_rx_timing

Overview:
- Receive-side counterpart of the VGA sync generator.
- Samples an incoming 640x480@60 stream (hsync, vsync, 3-bit rgb) on the pixel strobe and measures line and frame lengths.
- Recovers pixel_x/pixel_y, validates timing, and exposes locked pixels to a downstream frame-capture or loopback-check block.

Parameters:
H_TOTAL, 800, expected pixel ticks per line
V_TOTAL, 525, expected lines per frame
H_START, 144, receiver hcnt of first active pixel (hsync width 96 + back porch 48)
H_ACTIVE, 640, active pixels per line
V_START, 34, receiver vcnt of first active line
V_ACTIVE, 480, active lines per frame
CNT_MAX, 1023, saturation value of both counters (10 bit)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
p_tick  in  1  pixel-rate enable, one clk wide
hsync_in  in  1  incoming hsync, active-low
vsync_in  in  1  incoming vsync, active-low
rgb_in  in  3  incoming pixel colour
pixel_x  out  10  recovered column, 0..639
pixel_y  out  10  recovered row, 0..479
pix_valid  out  1  rgb_out is an active, locked pixel
rgb_out  out  3  delayed pixel colour
frame_start  out  1  one-clk pulse at vertical counter restart
locked  out  1  timing validated
h_total  out  10  last measured line length
v_total  out  10  last measured frame length
timing_err  out  1  one-clk pulse on timing violation

Behaviour:
- Reset:
  - Asserting reset (low) clears every register immediately, independent of clk.
  - All outputs are 0, except vcnt, which loads CNT_MAX (no frame seen yet).
- Clock enable: all state advances only on clk edges where p_tick=1. With p_tick=0, everything holds, except that frame_start and timing_err return to 0 on the next clk.
- Input stage: hsync_in, vsync_in and rgb_in are registered into s1 and then s2 on p_tick.
- Edge detect: a falling edge is s2=1 and s1=0, evaluated on the same tick.
- hcnt:
  - Loads 0 on an hsync falling edge.
  - Otherwise increments by 1, saturating at CNT_MAX.
  - On each hsync falling edge, h_total <= hcnt+1, except on the first edge after reset.
- vsync handling:
  - A vsync falling edge sets vs_pend.
  - On the next hsync falling edge: vcnt <= 0, v_total <= vcnt+1 (except the first frame), vs_pend cleared, frame_start pulses.
  - On other hsync falling edges, vcnt increments, saturating at CNT_MAX.
  - If both falling edges occur on the same tick, vs_pend is set and consumed on that same tick.
- Active window: hcnt in [H_START, H_START+H_ACTIVE-1] and vcnt in [V_START, V_START+V_ACTIVE-1].
- Output register (updated on p_tick):
  - pixel_x <= hcnt-H_START; pixel_y <= vcnt-V_START; rgb_out <= s2 rgb.
  - pix_valid <= window AND locked.
  - Outside the window, pixel_x and pixel_y hold their last values.
- Latency: rgb_in sampled at p_tick N appears on rgb_out after the clk edge of p_tick N+2.
- Lock FSM, states UNLOCK, CHECK, LOCK:
  - UNLOCK -> CHECK at the first frame_start.
  - CHECK -> LOCK at the next frame_start, if every line of that frame measured H_TOTAL and the frame measured V_TOTAL.
  - Any violation in CHECK or LOCK -> UNLOCK with a timing_err pulse.
  - locked=1 only in LOCK.
- Violations:
  - A measured line is not H_TOTAL.
  - A measured frame is not V_TOTAL.
  - hcnt reaches CNT_MAX (hsync lost; pulse once per saturation, not every tick).
  - vcnt reaches CNT_MAX while not in UNLOCK.
- Mid-frame reset: outputs go to 0 at once. Lock needs a fresh vsync plus one clean frame.

Test Plan:
- Ideal 800x525 generator, p_tick every 4 clk, 3 frames after reset -> locked=1 at the second frame_start (start of frame 3); h_total=800, v_total=525; no timing_err.
- Generator pixel (0,0)=3'b101 and (639,479)=3'b011 -> rgb_out=101 with x=0,y=0,pix_valid=1 two p_ticks later, and 011 with x=639,y=479; exactly 307200 pix_valid ticks per locked frame.
- One 799-tick line in a locked frame -> timing_err pulse at that line's end, h_total=799, locked=0; locked returns after the next two frame_starts with clean timing.
- hsync_in held high for 1100 ticks -> single timing_err when hcnt hits 1023, locked=0, pix_valid=0.
- reset driven low mid-line, between clk edges -> all outputs 0 before the next clk edge; after release, the frame restarts and locked=0 until two frame_starts pass.
- p_tick gated low for 50 clk mid-line -> hcnt, rgb_out and pixel_x frozen; no timing_err; line still measures 800 ticks.
